// File: rtl/shift_add_pkg.sv
// Shared definitions for the shift/add multiplier controller.
package shift_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/shift_counter.sv
// Iteration counter: synchronous clear, increment enable, terminal-count flag.
module shift_counter
  import shift_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)      count_d = '0;
    else if (inc) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  // tc flags the last iteration, seen before that iteration's increment
  assign tc    = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_add_controller.sv
// Control FSM for a shift/add multiplier; the datapath lives in external register/adder blocks.
module shift_add_controller
  import shift_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          q0,
  output logic          lds,
  output logic          clr,
  output logic          add_en,
  output logic          ebl,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);

  state_e state_q, state_d;
  logic   cnt_clr, cnt_inc, cnt_tc;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    lds     = 1'b0;
    clr     = 1'b0;
    add_en  = 1'b0;
    ebl     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        // clearing on entry makes count read 0 throughout LOAD
        if (start) begin
          state_d = LOAD;
          cnt_clr = 1'b1;
        end
      end
      LOAD: begin
        lds     = 1'b1;
        clr     = 1'b1;
        busy    = 1'b1;
        state_d = abort ? IDLE : EVAL;
      end
      EVAL: begin
        add_en  = q0;
        busy    = 1'b1;
        state_d = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        ebl     = 1'b1;
        busy    = 1'b1;
        // an aborted shift leaves count at the number of completed shifts
        cnt_inc = !abort;
        if (abort)       state_d = IDLE;
        else if (cnt_tc) state_d = DONE;
        else             state_d = EVAL;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  shift_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (count),
    .tc    (cnt_tc)
  );

endmodule

// File: tb/tb_shift_add_controller.sv
// Randomized scoreboard bench: a modelled multiplier register/accumulator closes the q0 loop.
module tb_shift_add_controller;

  localparam int W  = 8;
  localparam int CW = $clog2(W) + 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic lds, clr, add_en, ebl, busy, done, q0;
  logic [CW-1:0] count;

  logic [W-1:0]   mreg = '0, m_in = '0, a_in = '0;
  logic [2*W:0]   acc  = '0;
  int  cyc = 0, n_pass = 0, n_total = 0, exp_lds = 0, lds_total = 0;
  int  op_adds = 0, op_ebls = 0, lds_cyc = 0, last_done = 0;
  logic [W-1:0] mask = '0;
  bit  armed = 1'b0;

  typedef struct {
    logic [W-1:0]   m;
    logic [2*W-1:0] prod;
    int             exp_cyc;
    int             gap;
  } exp_t;
  exp_t q[$];
  exp_t e_m;

  shift_add_controller #(.WIDTH(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .q0(q0),
    .lds(lds), .clr(clr), .add_en(add_en), .ebl(ebl),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External datapath: multiplier shift register and accumulator with carry bit
  assign q0 = mreg[0];
  always @(posedge clk) begin
    if (lds === 1'b1) mreg <= m_in;
    if (clr === 1'b1) acc <= '0;
    if (add_en === 1'b1) acc[2*W:W] <= {1'b0, acc[2*W-1:W]} + {1'b0, a_in};
    if (ebl === 1'b1) begin
      acc  <= acc >> 1;
      mreg <= mreg >> 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp_v, cyc);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("excl", {61'd0, lds ^ clr, ($countones({lds, add_en, ebl}) > 1), (count > CW'(W))}, 64'd0);
      if (lds === 1'b1) begin
        lds_total++;
        op_adds = 0; op_ebls = 0; mask = '0; lds_cyc = cyc;
      end
      if (add_en === 1'b1) begin
        op_adds++;
        mask = mask | (W'(1) << op_ebls);
      end
      if (ebl === 1'b1) op_ebls++;
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          e_m = q.pop_front();
          chk("add_mask", mask, e_m.m);
          chk("add_pulses", op_adds, $countones(e_m.m));
          chk("ebl_pulses", op_ebls, W);
          chk("final_count", count, W);
          chk("product", acc[2*W-1:0], e_m.prod);
          chk("lat_from_load", cyc - lds_cyc, 2*W + 1);
          if (e_m.exp_cyc >= 0) chk("lat_from_start", cyc, e_m.exp_cyc);
          if (e_m.gap != 0) chk("done_gap", cyc - last_done, e_m.gap);
        end
        last_done = cyc;
      end
    end
  end

  // start is driven just after edge k and sampled at k+1; done shows after edge k+2+2W
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] mm, input bit push);
    logic [2*W-1:0] p;
    @(posedge clk); #1;
    a_in = a; m_in = mm; start = 1'b1; exp_lds++;
    p = a * mm;
    if (push) q.push_back('{m: mm, prod: p, exp_cyc: cyc + 2 + 2*W, gap: 0});
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL done_timeout: no done pulse by cycle %0d", cyc);
    end
  endtask

  task automatic wait_ebls(input int n);
    int seen = 0;
    for (int i = 0; i < 80 && seen < n; i++) begin
      @(negedge clk);
      if (ebl === 1'b1) seen++;
    end
    if (seen < n) begin
      n_total++;
      $display("FAIL ebl_timeout: saw %0d of %0d shifts", seen, n);
    end
  endtask

  // Optionally toggles start while busy; it returns low before the FSM reaches IDLE
  task automatic finish_op(input bit busy_start);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      start = busy_start ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    wait_done();
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] mm, input bit busy_start);
    launch(a, mm, 1'b1);
    finish_op(busy_start);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_reset_outs", {lds, clr, add_en, ebl, busy, done}, 6'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    armed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outs", {lds, clr, add_en, ebl, busy, done}, 6'd0);
      chk("idle_count", count, 0);
    end

    run_op(8'($urandom), 8'b10011101, 1'b0);
    run_op(8'($urandom), 8'h00, 1'b0);
    run_op(8'($urandom), 8'hFF, 1'b0);

    // abort in IDLE is inert and count holds its final value
    @(posedge clk); #1; abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle_busy", busy, 1'b0);
      chk("abort_idle_count", count, W);
    end
    #1; abort = 1'b0;

    // abort on the 4th shift
    launch(8'($urandom), 8'($urandom), 1'b0);
    @(posedge clk); #1; start = 1'b0;
    wait_ebls(4);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_count", count, 3);
    chk("abort_done", done, 1'b0);
    abort = 1'b0;
    run_op(8'($urandom), 8'($urandom), 1'b0);

    // start and abort together in IDLE: start wins
    launch(8'($urandom), 8'($urandom), 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_wins_lds", lds, 1'b1);
    wait_done();

    // reset during EVAL of iteration 5
    launch(8'($urandom), 8'($urandom), 1'b0);
    @(posedge clk); #1; start = 1'b0;
    wait_ebls(5);
    @(negedge clk);
    chk("in_eval5", {busy, ebl, lds}, 3'b100);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", {busy, done, lds}, 3'd0);
    chk("rst_mid_count", count, 0);
    rst = 1'b0;
    run_op(8'($urandom), 8'($urandom), 1'b0);

    // start held high: three back-to-back operations 19 cycles apart
    launch(8'h5A, 8'hC3, 1'b1);
    for (int i = 0; i < 2; i++) begin
      q.push_back('{m: 8'hC3, prod: 16'(8'h5A * 8'hC3), exp_cyc: -1, gap: 2*W + 3});
      exp_lds++;
    end
    repeat (3) wait_done();
    start = 1'b0;

    for (int i = 0; i < 20; i++) run_op(8'($urandom), 8'($urandom), 1'b1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    chk("lds_total", lds_total, exp_lds);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
